mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
// - Multicycle RV32I control unit: main FSM, ALU decoder and immediate-type decoder.
// - Consumes op/funct3/funct7b5 from the instruction register and zero from the ALU.
// - Drives datapath mux selects and register/memory enables, including immsrc for the immediate extender.
// - Sits between the instruction register and the datapath; one instruction in flight at a time.
// PARAMETERS
// - ILLEGAL_HALT  0  0: unknown opcode in DECODE returns to FETCH; 1: enters sticky HALT, asserts illegal.
// PORTS
// - clk          in   1  Single clock; all state updates on the rising edge.
// - reset        in   1  Synchronous, active-high.
// - op           in   7  instr[6:0].
// - funct3       in   3  instr[14:12].
// - funct7b5     in   1  instr[30].
// - zero         in   1  ALU result == 0; sampled in BEQ.
// - immsrc       out  2  00 I, 01 S, 10 B, 11 J.
// - alusrca      out  2  00 PC, 01 OldPC, 10 rs1 data.
// - alusrcb      out  2  00 rs2 data, 01 immext, 10 const 4.
// - resultsrc    out  2  00 ALUOut, 01 Data, 10 ALUResult.
// - adrsrc       out  1  0 PC, 1 Result.
// - alucontrol   out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
// - irwrite      out  1  Load instruction register.
// - pcwrite      out  1  = pcupdate | (branch & zero).
// - regwrite     out  1  Register-file write enable.
// - memwrite     out  1  Data-memory write enable.
// - illegal      out  1  Sticky illegal-opcode flag (ILLEGAL_HALT=1 only, else tied 0).
// BEHAVIOUR
// - Reset: state=FETCH next cycle. All enables=0 while reset is high; illegal cleared.
//   Selects take their FETCH encodings while reset is high.
// - Moore outputs by state; pcwrite is combinational on zero in BEQ only.
// - FETCH:    adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=1.
//   Transition: -> DECODE.
// - DECODE:   alusrca=01, alusrcb=01, aluop=00.
//   op 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI;
//   1100011 -> BEQ; 1101111 -> JAL; else -> FETCH, or HALT if ILLEGAL_HALT.
// - MEMADR:   alusrca=10, alusrcb=01, aluop=00.
//   Transition: lw -> MEMREAD; sw -> MEMWRITE.
// - MEMREAD:  resultsrc=00, adrsrc=1 -> MEMWB.
// - MEMWB:    resultsrc=01, regwrite=1 -> FETCH.
// - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1 -> FETCH.
// - EXECR:    alusrca=10, alusrcb=00, aluop=10 -> ALUWB.
// - EXECI:    alusrca=10, alusrcb=01, aluop=10 -> ALUWB.
// - ALUWB:    resultsrc=00, regwrite=1 -> FETCH.
// - BEQ:      alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1 -> FETCH.
// - JAL:      alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1 -> ALUWB.
// - HALT:     all enables 0, illegal=1; exits only on reset.
// - Cycles per instruction:
//   lw 5; sw 4; R/I 4; beq 3; jal 4.
// - ALU decode:
//   aluop 00 -> add; 01 -> sub.
//   aluop 10 with funct3 000 -> sub if (op[5] & funct7b5), else add.
//   aluop 10 with funct3 010 slt, 110 or, 111 and; other funct3 -> add.
// - immsrc: combinational from op in every state, so immext is valid in DECODE/MEMADR/EXECI/JAL.
//   lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
// - Unreachable state encodings recover to FETCH next cycle.
// - Reset mid-instruction aborts it; no enable pulses in the reset cycle.
// STRUCTURE
// - Shared package mc_ctrl_pkg: state enum, opcode localparams, aluop/alucontrol/immsrc encodings.
// - Sub-module alu_dec: aluop, funct3, op5, funct7b5 -> alucontrol (combinational).
// - FSM and immsrc decode stay in this module.
// TESTING
// - Reset, then lw (op=0000011):
//   states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regwrite=1 only in cycle 5; immsrc=00.
// - sw (op=0100011):
//   memwrite=1 only in cycle 4; regwrite never 1; immsrc=01.
// - beq (op=1100011): zero=1 -> pcwrite=1 in cycle 3; zero=0 -> pcwrite=0; immsrc=10.
// - R-type sub (funct3=000, funct7b5=1): alucontrol=001 in EXECR.
//   Same op with funct7b5=0 -> 000. addi with funct7b5=1 -> 000.
// - jal (op=1101111): cycle 3 pcwrite=1, alusrcb=10; cycle 4 ALUWB regwrite=1; immsrc=11.
// - op=1111111:
//   ILLEGAL_HALT=0 -> FETCH after DECODE.
//   ILLEGAL_HALT=1 -> HALT, illegal=1 held; reset mid-MEMREAD and in HALT returns to FETCH, illegal=0.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
//   state_t        : main FSM states
//   OP_*           : opcodes the controller recognises
//   ALUOP_*        : FSM-to-ALU-decoder operation class
//   ALU_*          : alucontrol encodings seen by the datapath ALU
//   IMM_*          : immediate extender format selects
//   imm_type()     : opcode -> immsrc
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_type(input logic [6:0] op);
        logic [1:0] t;
        t = IMM_I;
        case (op)
            OP_SW:   t = IMM_S;
            OP_BEQ:  t = IMM_B;
            OP_JAL:  t = IMM_J;
            default: t = IMM_I;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle.
//   master : control unit (consumes instruction fields and zero, drives controls)
//   slave  : datapath side (drives instruction fields and zero, consumes controls)
interface mc_control_fsm_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero,
        output immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
               irwrite, pcwrite, regwrite, memwrite, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
               irwrite, pcwrite, regwrite, memwrite, illegal
    );

endinterface

// File: rtl/mc_control_fsm_alu_dec.sv
// ALU decoder: maps the FSM's operation class plus instruction fields to
// the ALU control code.
//   aluop      in  2  operation class from the main FSM
//   funct3     in  3  instr[14:12]
//   op5        in  1  instr[5], distinguishes R-type from I-type
//   funct7b5   in  1  instr[30]
//   alucontrol out 3  ALU operation select
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct3)
                    // addi has no sub form, so funct7b5 only matters for R-type
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: main FSM, ALU decoder instance and
// immediate-type decode.
//   clk     in  clock, rising edge
//   reset   in  synchronous, active-high
//   bus     master modport of mc_control_fsm_if
//           in : op, funct3, funct7b5, zero
//           out: immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
//                irwrite, pcwrite, regwrite, memwrite, illegal
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instruction at PC, PC <= PC + 4
// DECODE   | read registers, compute branch/jump target
// MEMADR   | compute load/store address
// MEMREAD  | read data memory at computed address
// MEMWB    | write loaded data to register file
// MEMWRITE | write rs2 to data memory
// EXECR    | ALU on rs1, rs2
// EXECI    | ALU on rs1, immediate
// ALUWB    | write ALU result to register file
// BEQ      | compare rs1/rs2, take branch on zero
// JAL      | PC <= target, ALU forms return address
// HALT     | illegal opcode seen; waits for reset
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input logic               clk,
    input logic               reset,
    mc_control_fsm_if.master  bus
);

    state_t     state;
    state_t     state_next;

    logic [1:0] alusrca_q;
    logic [1:0] alusrcb_q;
    logic [1:0] resultsrc_q;
    logic       adrsrc_q;
    logic [1:0] aluop_q;
    logic       irwrite_q;
    logic       pcupdate_q;
    logic       branch_q;
    logic       regwrite_q;
    logic       memwrite_q;
    logic       illegal_q;
    logic [1:0] aluop_eff;

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECR;
                    OP_ITYPE:     state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            // only lw/sw reach MEMADR; op[5] is what separates them
            S_MEMADR:   state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_HALT:     state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so each state's Moore
    // values appear in the same cycle the state register does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            adrsrc_q    <= 1'b0;
            irwrite_q   <= 1'b1;
            alusrca_q   <= 2'b00;
            alusrcb_q   <= 2'b10;
            aluop_q     <= ALUOP_ADD;
            resultsrc_q <= 2'b10;
            pcupdate_q  <= 1'b1;
            branch_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state       <= state_next;
            adrsrc_q    <= 1'b0;
            irwrite_q   <= 1'b0;
            alusrca_q   <= 2'b00;
            alusrcb_q   <= 2'b00;
            aluop_q     <= ALUOP_ADD;
            resultsrc_q <= 2'b00;
            pcupdate_q  <= 1'b0;
            branch_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            illegal_q   <= ILLEGAL_HALT && (state_next == S_HALT);
            case (state_next)
                S_FETCH: begin
                    irwrite_q   <= 1'b1;
                    alusrcb_q   <= 2'b10;
                    resultsrc_q <= 2'b10;
                    pcupdate_q  <= 1'b1;
                end
                S_DECODE: begin
                    alusrca_q <= 2'b01;
                    alusrcb_q <= 2'b01;
                end
                S_MEMADR: begin
                    alusrca_q <= 2'b10;
                    alusrcb_q <= 2'b01;
                end
                S_MEMREAD: begin
                    adrsrc_q <= 1'b1;
                end
                S_MEMWB: begin
                    resultsrc_q <= 2'b01;
                    regwrite_q  <= 1'b1;
                end
                S_MEMWRITE: begin
                    adrsrc_q   <= 1'b1;
                    memwrite_q <= 1'b1;
                end
                S_EXECR: begin
                    alusrca_q <= 2'b10;
                    aluop_q   <= ALUOP_FUNCT;
                end
                S_EXECI: begin
                    alusrca_q <= 2'b10;
                    alusrcb_q <= 2'b01;
                    aluop_q   <= ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    regwrite_q <= 1'b1;
                end
                S_BEQ: begin
                    alusrca_q <= 2'b10;
                    aluop_q   <= ALUOP_SUB;
                    branch_q  <= 1'b1;
                end
                S_JAL: begin
                    alusrca_q  <= 2'b01;
                    alusrcb_q  <= 2'b10;
                    pcupdate_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // While reset is held the registers may still show the pre-reset state
    // for one cycle, so enables are masked and selects forced to FETCH values.
    assign aluop_eff     = reset ? ALUOP_ADD : aluop_q;
    assign bus.alusrca   = reset ? 2'b00 : alusrca_q;
    assign bus.alusrcb   = reset ? 2'b10 : alusrcb_q;
    assign bus.resultsrc = reset ? 2'b10 : resultsrc_q;
    assign bus.adrsrc    = reset ? 1'b0  : adrsrc_q;
    assign bus.irwrite   = irwrite_q  & ~reset;
    assign bus.regwrite  = regwrite_q & ~reset;
    assign bus.memwrite  = memwrite_q & ~reset;
    assign bus.illegal   = illegal_q  & ~reset;
    // zero is live in BEQ so the branch decision needs no extra cycle
    assign bus.pcwrite   = (pcupdate_q | (branch_q & bus.zero)) & ~reset;
    assign bus.immsrc    = imm_type(bus.op);

    alu_dec u_alu_dec (
        .aluop      (aluop_eff),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .alucontrol (bus.alucontrol)
    );

endmodule
